// File: rtl/alu_result_adapter_pkg.sv
// Shared codes for the ALU result adapter: write-back selects,
// multiply/divide opcodes and the engine state encoding.
package alu_result_adapter_pkg;

  localparam int DEFAULT_DATA_BITS = 32;

  // Code 3 is reserved and falls back to the ALU word.
  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_HI  = 2'd1,
    RES_LO  = 2'd2
  } res_sel_e;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  function automatic logic isSignedOp(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic isDivOp(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/alu_result_adapter_divstep.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and shift the
// resulting quotient bit in from the right.
module restoring_divider_step #(
  parameter int DATA_BITS = 32
) (
  input  logic [DATA_BITS-1:0] rem_i,
  input  logic [DATA_BITS-1:0] quo_i,
  input  logic [DATA_BITS-1:0] divisor_i,
  output logic [DATA_BITS-1:0] rem_o,
  output logic [DATA_BITS-1:0] quo_o
);

  logic [DATA_BITS:0] trial;
  logic [DATA_BITS:0] diff;

  // Trial subtraction one bit wider than the datapath so the borrow is visible.
  always_comb begin
    trial = {rem_i, quo_i[DATA_BITS-1]};
    diff  = trial - {1'b0, divisor_i};
    if (!diff[DATA_BITS]) begin
      rem_o = diff[DATA_BITS-1:0];
      quo_o = {quo_i[DATA_BITS-2:0], 1'b1};
    end else begin
      rem_o = trial[DATA_BITS-1:0];
      quo_o = {quo_i[DATA_BITS-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_result_adapter.sv
// Write-back side of the ALU: owns HI/LO, runs a one-cycle multiplier and
// a DATA_BITS-cycle restoring divider, and selects the RegFile write word.
module alu_result_adapter
  import alu_result_adapter_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] AluResult,
  input  logic [DATA_BITS-1:0] OpA,
  input  logic [DATA_BITS-1:0] OpB,
  input  logic [1:0]           ResultSel,
  input  logic                 MdStart,
  input  logic [1:0]           MdOp,
  input  logic                 HiWrite,
  input  logic                 LoWrite,
  output logic [DATA_BITS-1:0] RegWriteData,
  output logic                 MdBusy,
  output logic [DATA_BITS-1:0] Hi,
  output logic [DATA_BITS-1:0] Lo
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_BITS - 1);

  md_state_e state_q;
  logic [CNT_W-1:0] count_q;
  logic [DATA_BITS-1:0] hi_q, lo_q;
  logic [DATA_BITS-1:0] opA_q, opB_q;
  logic signed_q;
  logic [DATA_BITS-1:0] rem_q, quo_q, divisor_q;
  logic negQuo_q, negRem_q;

  md_op_e op;
  logic opSigned;
  logic negA, negB;
  logic [DATA_BITS-1:0] magA, magB;
  logic [DATA_BITS-1:0] rem_d, quo_d;
  logic [2*DATA_BITS-1:0] product_d;
  logic [DATA_BITS-1:0] divHi_d, divLo_d;

  // Operand magnitudes and sign flags taken when a divide is launched.
  always_comb begin
    op       = md_op_e'(MdOp);
    opSigned = isSignedOp(op);
    negA     = opSigned && OpA[DATA_BITS-1];
    negB     = opSigned && OpB[DATA_BITS-1];
    magA     = negA ? -OpA : OpA;
    magB     = negB ? -OpB : OpB;
  end

  restoring_divider_step #(.DATA_BITS(DATA_BITS)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  // Full-width product of the captured operands, signed or unsigned.
  always_comb begin
    if (signed_q) begin
      product_d = $signed({{DATA_BITS{opA_q[DATA_BITS-1]}}, opA_q}) *
                  $signed({{DATA_BITS{opB_q[DATA_BITS-1]}}, opB_q});
    end else begin
      product_d = {{DATA_BITS{1'b0}}, opA_q} * {{DATA_BITS{1'b0}}, opB_q};
    end
  end

  // Final divide results from the last iteration: sign fix-up, and a zero
  // divisor returns the dividend in HI and all ones in LO.
  always_comb begin
    divLo_d = negQuo_q ? -quo_d : quo_d;
    divHi_d = negRem_q ? -rem_d : rem_d;
    if (opB_q == '0) begin
      divLo_d = '1;
      divHi_d = opA_q;
    end
  end

  // Engine state machine; HI/LO only change on MTHI/MTLO or a result write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      signed_q  <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      negQuo_q  <= 1'b0;
      negRem_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (MdStart) begin
            opA_q    <= OpA;
            opB_q    <= OpB;
            signed_q <= opSigned;
            if (isDivOp(op)) begin
              rem_q     <= '0;
              quo_q     <= magA;
              divisor_q <= magB;
              negQuo_q  <= negA ^ negB;
              negRem_q  <= negA;
              count_q   <= '0;
              state_q   <= ST_DIV;
            end else begin
              state_q <= ST_MUL;
            end
          end else begin
            if (HiWrite) hi_q <= OpA;
            if (LoWrite) lo_q <= OpA;
          end
        end
        ST_MUL: begin
          hi_q    <= product_d[2*DATA_BITS-1:DATA_BITS];
          lo_q    <= product_d[DATA_BITS-1:0];
          state_q <= ST_IDLE;
        end
        ST_DIV: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q + CNT_W'(1);
          if (count_q == LAST_ITER) begin
            hi_q    <= divHi_d;
            lo_q    <= divLo_d;
            count_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write-back select straight from the current registers, no forwarding.
  always_comb begin
    case (res_sel_e'(ResultSel))
      RES_HI:  RegWriteData = hi_q;
      RES_LO:  RegWriteData = lo_q;
      default: RegWriteData = AluResult;
    endcase
  end

  assign MdBusy = (state_q != ST_IDLE);
  assign Hi     = hi_q;
  assign Lo     = lo_q;

endmodule

// File: tb/tb_alu_result_adapter.sv
// Scoreboard bench for alu_result_adapter: each mult/div launch queues its
// expected HI/LO and busy length; a monitor checks them when busy drops.
module tb_alu_result_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AluResult, OpA, OpB;
  logic [1:0]  ResultSel, MdOp;
  logic        MdStart, HiWrite, LoWrite;
  logic [31:0] RegWriteData, Hi, Lo;
  logic        MdBusy;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busyLen;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   checkCount = 0;
  int   passCount  = 0;
  int   busyLen    = 0;

  alu_result_adapter #(.DATA_BITS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .AluResult    (AluResult),
    .OpA          (OpA),
    .OpB          (OpB),
    .ResultSel    (ResultSel),
    .MdStart      (MdStart),
    .MdOp         (MdOp),
    .HiWrite      (HiWrite),
    .LoWrite      (LoWrite),
    .RegWriteData (RegWriteData),
    .MdBusy       (MdBusy),
    .Hi           (Hi),
    .Lo           (Lo)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one mult/div and queue what it should leave in HI/LO.
  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi,
                               input logic [31:0] expLo, input int expLen);
    MdOp    = op;
    OpA     = a;
    OpB     = b;
    MdStart = 1'b1;
    expQ.push_back('{name, expHi, expLo, expLen});
    tick;
    MdStart = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (MdBusy && n < 100) begin
      tick;
      n++;
    end
    if (MdBusy) begin
      checkCount++;
      $display("[TB] FAIL %s timeout: busy still 1 after %0d cycles, required 0", name, n);
    end
    @(negedge clk);
    #1;
  endtask

  // Monitor: counts busy cycles and checks an operation when busy falls.
  always @(negedge clk) begin
    if (MdBusy === 1'b1) begin
      busyLen++;
    end else if (busyLen > 0) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected completion: busy for %0d cycles, no operation queued", busyLen);
      end else begin
        cur = expQ.pop_front();
        checkOutput({cur.name, " Hi"}, Hi, cur.hi);
        checkOutput({cur.name, " Lo"}, Lo, cur.lo);
        if (cur.busyLen > 0) checkOutput({cur.name, " busy cycles"}, busyLen, cur.busyLen);
      end
      busyLen = 0;
    end
  end

  initial begin
    rst = 1'b1; AluResult = '0; OpA = '0; OpB = '0; ResultSel = 2'd0;
    MdStart = 1'b0; MdOp = 2'd0; HiWrite = 1'b0; LoWrite = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    AluResult = 32'h0000_1234;
    #1;
    checkOutput("reset RegWriteData ALU", RegWriteData, 32'h0000_1234);
    checkOutput("reset Hi", Hi, 32'h0);
    checkOutput("reset Lo", Lo, 32'h0);
    checkOutput("reset MdBusy", {31'b0, MdBusy}, 32'h0);

    applyStimulus("MULT -2*3", 2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1);
    waitIdle("MULT -2*3");
    applyStimulus("MULTU", 2'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1);
    waitIdle("MULTU");
    applyStimulus("MULT min*min", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1);
    waitIdle("MULT min*min");

    applyStimulus("DIV -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32);
    waitIdle("DIV -7/2");
    applyStimulus("DIV 7/-2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 32);
    waitIdle("DIV 7/-2");
    applyStimulus("DIVU 7/2", 2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 32);
    waitIdle("DIVU 7/2");

    ResultSel = 2'd1;
    #1 checkOutput("RegWriteData HI", RegWriteData, 32'd1);
    ResultSel = 2'd3; AluResult = 32'h0000_A5A5;
    #1 checkOutput("RegWriteData reserved sel", RegWriteData, 32'h0000_A5A5);
    ResultSel = 2'd2; LoWrite = 1'b1; OpA = 32'hDEAD_BEEF;
    #1 checkOutput("MTLO same-cycle read old LO", RegWriteData, 32'd3);
    tick;
    LoWrite = 1'b0;
    checkOutput("MTLO next-cycle read", RegWriteData, 32'hDEAD_BEEF);
    checkOutput("MTLO Hi untouched", Hi, 32'd1);

    applyStimulus("DIVU 5/0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 32);
    waitIdle("DIVU 5/0");
    applyStimulus("DIV -5/0", 2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32);
    waitIdle("DIV -5/0");
    applyStimulus("DIV min/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32);
    waitIdle("DIV min/-1");

    OpA = 32'h1111_1111; HiWrite = 1'b1; LoWrite = 1'b1;
    tick;
    HiWrite = 1'b0; LoWrite = 1'b0;
    checkOutput("MTHI+MTLO Hi", Hi, 32'h1111_1111);
    checkOutput("MTHI+MTLO Lo", Lo, 32'h1111_1111);

    HiWrite = 1'b1;
    applyStimulus("MULTU 5*6 with MTHI", 2'd1, 32'd5, 32'd6, 32'h0, 32'd30, 1);
    HiWrite = 1'b0;
    checkOutput("MTHI dropped under MdStart", Hi, 32'h1111_1111);
    checkOutput("busy after start", {31'b0, MdBusy}, 32'h1);
    waitIdle("MULTU 5*6");

    applyStimulus("DIVU 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 32);
    repeat (4) tick;
    MdOp = 2'd0; OpA = 32'd3; OpB = 32'd4; MdStart = 1'b1; HiWrite = 1'b1;
    tick;
    MdStart = 1'b0; HiWrite = 1'b0;
    checkOutput("busy-time MTHI ignored", Hi, 32'h0);
    waitIdle("DIVU 100/7");

    applyStimulus("aborted DIVU", 2'd3, 32'd100, 32'd7, 32'h0, 32'h0, 0);
    repeat (9) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkOutput("abort MdBusy", {31'b0, MdBusy}, 32'h0);
    checkOutput("abort Hi", Hi, 32'h0);
    checkOutput("abort Lo", Lo, 32'h0);
    repeat (40) tick;
    checkOutput("no late write Hi", Hi, 32'h0);
    checkOutput("no late write Lo", Lo, 32'h0);

    repeat (2) tick;
    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
